// File: rtl/spi_slave.sv
// spi_slave: single-slave SPI responder running on the system clock (no SCLK).
// While SS_n is low it shifts a DATALEN-bit word in from MOSI and shifts the
// preloaded tx word out on MISO. Both directions are LSB first and use the same cycles.
// The first low cycle of SS_n is a request cycle and carries no data.
//
// Ports:
//   clock, reset      system clock, async active-high reset
//   SS_n, MOSI        slave select (active low) and serial data from master
//   MISO              serial data to master (0 outside the data phase)
//   tx_data, tx_load  word for the next frame and its load strobe (IDLE only)
//   tx_ready          high while a load would be accepted
//   rx_data, rx_valid last complete received word, one-cycle update pulse
//   busy              frame in progress
//   frame_error       one-cycle pulse when a frame is aborted early
module spi_slave #(
  parameter int DATALEN = 64,
  parameter int CNTW    = $clog2(DATALEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [DATALEN-1:0] tx_data,
  input  logic               tx_load,
  output logic               tx_ready,
  output logic [DATALEN-1:0] rx_data,
  output logic               rx_valid,
  output logic               busy,
  output logic               frame_error
);

  localparam int              IDXW = $clog2(DATALEN);
  localparam logic [CNTW-1:0] LAST = CNTW'(DATALEN - 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q;
  logic [DATALEN-1:0] tx_reg, shift_reg, rx_word;
  logic [IDXW-1:0]    idx;
  logic               load_en, sample, last_bit, abort;

  // cnt_q never passes DATALEN-1 while sampling, so its low bits are a valid index.
  assign idx = cnt_q[IDXW-1:0];

  // The received word including the bit sampled this cycle. This lets the last
  // bit go straight into rx_data without an extra cycle of latency.
  always_comb begin
    rx_word      = shift_reg;
    rx_word[idx] = MOSI;
  end

  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    sample   = 1'b0;
    last_bit = 1'b0;
    abort    = 1'b0;
    tx_ready = 1'b0;
    MISO     = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        load_en  = tx_load;   // a load in the request cycle still applies to this frame
        if (!SS_n) state_d = RECV;
      end
      RECV: begin
        MISO = tx_reg[idx];
        if (!SS_n) begin
          sample = 1'b1;
          if (cnt_q == LAST) begin
            last_bit = 1'b1;
            state_d  = DONE;
          end
        end else begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        // Wait for SS_n to go high, so a continuous-low SS_n never starts a second frame.
        if (SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_reg      <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid    <= last_bit;
      frame_error <= abort;
      if (load_en) tx_reg <= tx_data;
      if (state_q == IDLE) cnt_q <= '0;
      if (sample) begin
        shift_reg <= rx_word;
        cnt_q     <= last_bit ? '0 : cnt_q + CNTW'(1);
      end
      if (last_bit) rx_data <= rx_word;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized self-checking bench for spi_slave (DATALEN=64).
// The reference model keeps only the current tx word and the last received word.
// Expected MISO bits, rx_data and the pulses follow directly from the frame
// shape that the master task drives.
module tb_spi_slave;
  localparam int DL = 64;
  localparam logic [DL-1:0] ONE  = 64'd1;
  localparam logic [DL-1:0] ZERO = 64'd0;

  logic          clock = 1'b0;
  logic          reset, SS_n, MOSI, tx_load;
  logic          MISO, tx_ready, rx_valid, busy, frame_error;
  logic [DL-1:0] tx_data, rx_data;

  logic [DL-1:0] m_tx, m_rx;
  int            n_cmp = 0;
  int            n_err = 0;

  spi_slave #(.DATALEN(DL)) dut (
    .clock(clock), .reset(reset), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DL-1:0] got, input logic [DL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DL-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Load a word while idle. The call starts and ends at a negedge.
  task automatic load_word(input logic [DL-1:0] w);
    chk("tx_ready_idle", 64'(tx_ready), ONE);
    tx_load = 1'b1;
    tx_data = w;
    @(negedge clock);
    tx_load = 1'b0;
    m_tx    = w;
  endtask

  // Master side of one frame, starting at a negedge in IDLE.
  // nbits < DL aborts the frame after that many bits. extra is the number of
  // cycles SS_n is held low past the last bit. mid_ld >= 0 pulses tx_load
  // during that data bit.
  task automatic frame(input logic [DL-1:0] word, input int nbits, input int extra,
                       input bit ld_fall, input logic [DL-1:0] ld_word, input int mid_ld);
    SS_n = 1'b0;
    if (ld_fall) begin
      tx_load = 1'b1;
      tx_data = ld_word;
      m_tx    = ld_word;
    end
    @(negedge clock);
    tx_load = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      chk("miso_bit", 64'(MISO), 64'(m_tx[i]));
      chk("busy_recv", 64'(busy), ONE);
      chk("tx_ready_recv", 64'(tx_ready), ZERO);
      chk("rx_valid_early", 64'(rx_valid), ZERO);
      MOSI = word[i];
      if (i == mid_ld) begin
        tx_load = 1'b1;
        tx_data = '1;
      end else begin
        tx_load = 1'b0;
      end
      @(negedge clock);
    end
    tx_load = 1'b0;
    if (nbits < DL) begin
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clock);
      chk("abort_err", 64'(frame_error), ONE);
      chk("abort_valid", 64'(rx_valid), ZERO);
      chk("abort_busy", 64'(busy), ZERO);
      chk("abort_rx_data", rx_data, m_rx);
      @(negedge clock);
      chk("abort_err_pulse", 64'(frame_error), ZERO);
    end else begin
      m_rx = word;
      chk("rx_valid", 64'(rx_valid), ONE);
      chk("rx_data", rx_data, m_rx);
      chk("done_err", 64'(frame_error), ZERO);
      chk("done_miso", 64'(MISO), ZERO);
      chk("done_busy", 64'(busy), ONE);
      for (int e = 0; e < extra; e++) begin
        MOSI = $urandom_range(0, 1) != 0;
        @(negedge clock);
        chk("extra_valid", 64'(rx_valid), ZERO);
        chk("extra_rx_data", rx_data, m_rx);
        chk("extra_miso", 64'(MISO), ZERO);
        chk("extra_tx_ready", 64'(tx_ready), ZERO);
      end
      SS_n = 1'b1;
      @(negedge clock);
      chk("idle_busy", 64'(busy), ZERO);
      chk("idle_tx_ready", 64'(tx_ready), ONE);
      chk("idle_valid", 64'(rx_valid), ZERO);
    end
  endtask

  initial begin
    reset = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_load = 1'b0; tx_data = '0;
    m_tx = '0; m_rx = '0;
    #1;
    chk("rst_rx_valid", 64'(rx_valid), ZERO);
    chk("rst_frame_error", 64'(frame_error), ZERO);
    chk("rst_busy", 64'(busy), ZERO);
    chk("rst_miso", 64'(MISO), ZERO);
    chk("rst_tx_ready", 64'(tx_ready), ONE);
    chk("rst_rx_data", rx_data, ZERO);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic frame.
    load_word(64'hA5A5_0000_FFFF_1234);
    frame(64'h0123_4567_89AB_CDEF, DL, 0, 1'b0, '0, -1);
    // One extra low cycle after the last bit.
    frame(rnd64(), DL, 1, 1'b0, '0, -1);
    // Abort after 20 bits, then a good frame.
    frame(rnd64(), 20, 0, 1'b0, '0, -1);
    frame(rnd64(), DL, 0, 1'b0, '0, -1);
    // A load during RECV is ignored. The next frame still sends the old word.
    frame(rnd64(), DL, 0, 1'b0, '0, 10);
    frame(rnd64(), DL, 0, 1'b0, '0, -1);
    // A load in the cycle SS_n falls is used for that frame.
    frame(rnd64(), DL, 0, 1'b1, 64'hDEAD_BEEF_0F0F_1357, -1);
    // Back-to-back frames with one idle cycle between them.
    frame(64'h1, DL, 0, 1'b0, '0, -1);
    frame(64'h8000_0000_0000_0000, DL, 0, 1'b0, '0, -1);

    // Random frames.
    for (int k = 0; k < 24; k++) begin
      int nb, ex, ml;
      bit lf;
      if ($urandom_range(0, 3) == 0) load_word(rnd64());
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DL - 1)) : DL;
      ex = $urandom_range(0, 3);
      lf = $urandom_range(0, 2) == 0;
      ml = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      frame(rnd64(), nb, ex, lf, rnd64(), ml);
    end

    // Reset in the middle of a frame.
    SS_n = 1'b0;
    repeat (12) begin
      MOSI = $urandom_range(0, 1) != 0;
      @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    m_tx = '0; m_rx = '0;
    chk("midrst_valid", 64'(rx_valid), ZERO);
    chk("midrst_err", 64'(frame_error), ZERO);
    chk("midrst_busy", 64'(busy), ZERO);
    chk("midrst_miso", 64'(MISO), ZERO);
    chk("midrst_tx_ready", 64'(tx_ready), ONE);
    chk("midrst_rx_data", rx_data, ZERO);
    SS_n = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    frame(rnd64(), DL, 0, 1'b0, '0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Single-slave SPI responder. It is the other end of the team's SPI master, runs on the same system clock, and has no separate SCLK.
- While SS_n is low it shifts a DATALEN-bit word in from MOSI, LSB first, and shifts a preloaded word out on MISO, LSB first, in the same cycles.
- It presents the received word to the local logic with a one-cycle valid pulse.

Parameters:
- DATALEN, 64, bits per frame in each direction (>=2).
- CNTW, $clog2(DATALEN+1), width of the bit counter (derived; do not override).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- SS_n  input  1  slave select from the master, active-low.
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master.
- tx_data  input  DATALEN  word to return to the master on the next frame.
- tx_load  input  1  load strobe for tx_data.
- tx_ready  output  1  high when tx_load will be accepted.
- rx_data  output  DATALEN  last complete received word.
- rx_valid  output  1  one-cycle pulse, rx_data newly updated.
- busy  output  1  frame in progress (state != IDLE).
- frame_error  output  1  one-cycle pulse, frame aborted.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, bit counter=0.
  - tx_reg=0, shift_reg=0, rx_data=0.
  - Outputs: rx_valid=0, frame_error=0, busy=0, MISO=0, tx_ready=1.
- States:
  - IDLE:
    - tx_ready=1, MISO=0.
    - tx_load=1 captures tx_data into tx_reg at the clock edge.
    - SS_n sampled low -> RECV, counter=0.
    - The request cycle (SS_n first low) carries no data and is not sampled.
  - RECV:
    - tx_ready=0; tx_load is ignored with no side effect.
    - MISO = tx_reg[counter], combinational from registered state.
    - Each edge with SS_n=0: shift_reg[counter] <= MOSI, counter++.
    - When counter==DATALEN-1 is sampled:
      - rx_data <= assembled word including this bit.
      - rx_valid=1 for exactly the next cycle.
      - -> DONE.
    - SS_n sampled high before the last bit:
      - -> IDLE, frame_error pulses 1 cycle.
      - rx_data unchanged, rx_valid stays 0.
  - DONE:
    - MISO=0; extra cycles the master holds SS_n low are ignored (no sampling).
    - SS_n sampled high -> IDLE.
    - tx_ready=0 until IDLE.
- Latency: rx_valid asserts the cycle after the DATALEN-th sampled bit.
- A frame occupies 1 request cycle + DATALEN RECV cycles + >=1 DONE cycle.
- Back-to-back frames: SS_n must return high for >=1 cycle between frames. A continuous-low SS_n never starts a second frame.
- tx_reg is not cleared by a frame; the same word is resent until reloaded.
- tx_load in the same cycle SS_n first goes low in IDLE: load wins. The new word is used for this frame.
- rx_valid and frame_error are never high together.
- rx_data holds its value until the next complete frame; there is no overrun flag.
- Reset mid-frame: immediate return to reset values. No rx_valid or frame_error pulse is generated.
- Counter width CNTW; it never exceeds DATALEN-1 in RECV.

Test Plan:
- Reset: assert reset mid-clock -> all outputs at reset values immediately; busy=0, tx_ready=1.
- Basic frame, DATALEN=64:
  - Stimulus: tx_load with 64'hA5A5_0000_FFFF_1234; master sends 64'h0123_4567_89AB_CDEF LSB first after 1 request cycle.
  - Required: MISO bit sequence equals tx word LSB first (first bit 0, since 0x4=0100).
  - Required: rx_data=64'h0123_4567_89AB_CDEF and a single-cycle rx_valid, 65 cycles after SS_n falls.
- Master holds SS_n low for 1 extra cycle (65 data cycles) -> the extra MOSI bit is ignored; exactly one rx_valid; rx_data unchanged by it.
- Abort: SS_n high after 20 bits -> frame_error pulses once; rx_data keeps its previous value; state returns to IDLE; the next full frame is received correctly.
- Load rules:
  - tx_load during RECV with 64'hFFFF... -> ignored; the following frame sends the old tx word.
  - tx_load in the same cycle SS_n falls -> the new word is sent.
- Back-to-back frames with 1 idle cycle between, words 64'h1 then 64'h8000_0000_0000_0000 -> two rx_valid pulses with the correct words; MISO repeats tx_reg in both frames.
